// File: rtl/sram_burst_master_if.sv
// Command, write-beat and read-beat channels between a burst initiator
// (master) and sram_burst_master (slave).
interface sram_burst_master_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int WIDTH      = 64,
    parameter int LEN_WIDTH  = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [WIDTH-1:0]      wr_data;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [WIDTH-1:0]      rd_data;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/sram_burst_master.sv
// Turns burst read/write commands into single-beat SRAM bank accesses; read
// beats return through a 4-entry FIFO that absorbs the bank's 1-cycle latency.
module sram_burst_master #(
    parameter int ADDR_WIDTH = 10,
    parameter int WIDTH      = 64,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_burst_master_if.slave    bus,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_enable,
    output logic                  sram_write_en,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [WIDTH-1:0]      sram_wdata,
    input  logic [WIDTH-1:0]      sram_rdata
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [LEN_WIDTH-1:0]  pop_cnt;
    logic [1:0]            inflight;
    logic [WIDTH-1:0]      fifo [4];
    logic [1:0]            wptr;
    logic [1:0]            rptr;
    logic [2:0]            count;
    logic                  done_q;
    logic                  done_next;
    logic                  accept;
    logic                  write_beat;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  fifo_valid;
    logic [3:0]            credit_used;

    assign fifo_valid = (count != 3'd0);
    assign pop        = fifo_valid & bus.rd_ready;
    assign push       = (inflight != 2'd0);

    // FIFO slots already spoken for: buffered beats plus reads still returning
    // from the bank, less the beat leaving this cycle.
    assign credit_used = 4'(count) + 4'(inflight) - 4'(pop);

    assign bus.rd_valid = fifo_valid;
    assign bus.rd_data  = fifo_valid ? fifo[rptr] : '0;
    assign busy         = (state != IDLE);
    assign done         = done_q;

    always_comb begin
        state_next    = state;
        done_next     = 1'b0;
        accept        = 1'b0;
        write_beat    = 1'b0;
        issue         = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        sram_enable   = 1'b0;
        sram_write_en = 1'b0;
        sram_addr     = '0;
        sram_wdata    = '0;
        unique case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept     = 1'b1;
                    state_next = bus.cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                bus.wr_ready = 1'b1;
                if (bus.wr_valid) begin
                    write_beat    = 1'b1;
                    sram_enable   = 1'b1;
                    sram_write_en = 1'b1;
                    sram_addr     = cur_addr;
                    sram_wdata    = bus.wr_data;
                    if (beat_cnt == len_q) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            READ: begin
                if (credit_used < 4'd4) begin
                    issue       = 1'b1;
                    sram_enable = 1'b1;
                    sram_addr   = cur_addr;
                    if (beat_cnt == len_q) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && (pop_cnt == len_q)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            cur_addr <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            pop_cnt  <= '0;
            inflight <= 2'd0;
            wptr     <= 2'd0;
            rptr     <= 2'd0;
            count    <= 3'd0;
        end else begin
            state  <= state_next;
            done_q <= done_next;
            if (accept) begin
                cur_addr <= bus.cmd_addr;
                len_q    <= bus.cmd_len;
                beat_cnt <= '0;
            end else if (write_beat || issue) begin
                cur_addr <= cur_addr + ADDR_WIDTH'(1);
                beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            end
            if (accept) begin
                pop_cnt <= '0;
            end else if (pop) begin
                pop_cnt <= pop_cnt + LEN_WIDTH'(1);
            end
            inflight <= inflight + 2'(issue) - 2'(push);
            if (push) begin
                wptr <= wptr + 2'd1;
            end
            if (pop) begin
                rptr <= rptr + 2'd1;
            end
            count <= count + 3'(push) - 3'(pop);
        end
    end

    // Storage needs no reset: a flushed FIFO never presents its stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wptr] <= sram_rdata;
        end
    end
endmodule

// File: tb/tb_sram_burst_master.sv
// Randomized scoreboard bench for sram_burst_master against a bank model and
// a word-array reference of the SRAM contents.
module tb_sram_burst_master;
    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int LW    = 8;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy;
    logic          done;
    logic          sram_enable;
    logic          sram_write_en;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    int compared      = 0;
    int mismatched    = 0;
    int done_seen     = 0;
    int done_exp      = 0;
    int rd_issued     = 0;
    int rd_popped     = 0;
    int wr_access_cnt = 0;
    int rd_mode       = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] bank_mem [DEPTH];
    acc_t          wexp_q [$];
    logic [AW-1:0] raddr_q [$];
    logic [DW-1:0] rdata_q [$];

    sram_burst_master_if #(.ADDR_WIDTH(AW), .WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    sram_burst_master #(.ADDR_WIDTH(AW), .WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .sram_enable  (sram_enable),
        .sram_write_en(sram_write_en),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int a);
        return {32'h5A5A_0000 + 32'(a), 32'hC3C3_0000 ^ 32'(a * 7)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name, input string why);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: %s", name, why);
    endtask

    // Bank model: writes land at the edge, read data appears one cycle later.
    initial begin
        for (int i = 0; i < DEPTH; i++) bank_mem[i] <= init_word(i);
        sram_rdata <= '0;
        forever begin
            @(posedge clk);
            if (sram_enable) begin
                if (sram_write_en) bank_mem[sram_addr] <= sram_wdata;
                else sram_rdata <= bank_mem[sram_addr];
            end
        end
    end

    initial begin
        bus.rd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rd_mode)
                0:       bus.rd_ready = 1'b1;
                1:       bus.rd_ready = !bus.rd_ready;
                default: bus.rd_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: every SRAM access and every popped beat is checked against the scoreboard.
    initial begin
        acc_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sram_enable && sram_write_en) begin
                    wr_access_cnt++;
                    if (wexp_q.size() == 0) reportFail("sram_write", "write access with none expected");
                    else begin
                        e = wexp_q.pop_front();
                        checkOutput("sram_write_addr", 64'(sram_addr), 64'(e.addr));
                        checkOutput("sram_write_data", sram_wdata, e.data);
                    end
                end
                if (sram_enable && !sram_write_en) begin
                    rd_issued++;
                    if (raddr_q.size() == 0) reportFail("sram_read", "read access with none expected");
                    else checkOutput("sram_read_addr", 64'(sram_addr), 64'(raddr_q.pop_front()));
                end
                if (bus.rd_valid && bus.rd_ready) begin
                    rd_popped++;
                    if (rdata_q.size() == 0) reportFail("rd_data", "beat delivered with none outstanding");
                    else checkOutput("rd_data", bus.rd_data, rdata_q.pop_front());
                end
                if (rd_issued - rd_popped > 4)
                    reportFail("fifo_occupancy", $sformatf("%0d reads outstanding, limit 4", rd_issued - rd_popped));
                if (done) done_seen++;
                checkOutput("cmd_ready_only_idle", 64'(bus.cmd_ready), 64'(!busy));
            end
        end
    end

    task automatic applyStimulus(input bit write, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                                 input int wv_mode, input logic [DW-1:0] data_base);
        logic          rdy;
        logic          dn;
        int            waited;
        int            taken;
        int            k;
        logic [AW-1:0] a;
        logic [DW-1:0] beat [256];
        rdy    = 1'b0;
        dn     = 1'b0;
        waited = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = write;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        for (int n = 0; n < 3000 && !rdy; n++) begin
            @(negedge clk);
            rdy = bus.cmd_ready;
            dn  = done;
            @(posedge clk);
            #1;
            if (!rdy) waited++;
        end
        bus.cmd_valid = 1'b0;
        if (!rdy) begin
            reportFail("cmd_accept", "command not accepted within 3000 cycles");
            return;
        end
        if (waited > 0) checkOutput("accept_in_done_cycle", 64'(dn), 64'(1));
        done_exp++;
        for (int i = 0; i <= int'(len); i++) begin
            a = AW'((int'(addr) + i) % DEPTH);
            if (write) begin
                beat[i] = (data_base != 0) ? data_base + DW'(i) : {$urandom, $urandom};
                ref_mem[a] = beat[i];
                wexp_q.push_back('{addr: a, data: beat[i]});
            end else begin
                raddr_q.push_back(a);
                rdata_q.push_back(ref_mem[a]);
            end
        end
        if (write) begin
            taken = 0;
            k     = 0;
            while (taken <= int'(len) && k < 4000) begin
                case (wv_mode)
                    0:       bus.wr_valid = 1'b1;
                    1:       bus.wr_valid = (k % 4 == 0) || (k % 4 == 3);
                    default: bus.wr_valid = ($urandom_range(0, 3) != 0);
                endcase
                bus.wr_data = beat[taken];
                @(negedge clk);
                if (!bus.wr_valid) checkOutput("no_access_in_gap", 64'(sram_enable), 64'(0));
                rdy = bus.wr_valid & bus.wr_ready;
                @(posedge clk);
                #1;
                if (rdy) taken++;
                k++;
            end
            bus.wr_valid = 1'b0;
            if (taken <= int'(len)) reportFail("write_beats", "write burst did not consume all beats");
            else if (wv_mode == 0) checkOutput("write_burst_cycles", 64'(k), 64'(int'(len) + 1));
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((busy || rdata_q.size() != 0 || raddr_q.size() != 0 || wexp_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) reportFail("wait_idle", "burst did not finish within 5000 cycles");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        reportFail("watchdog", "simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int dseen;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        checkOutput("reset_wr_ready", 64'(bus.wr_ready), 64'(0));
        checkOutput("reset_rd_valid", 64'(bus.rd_valid), 64'(0));
        checkOutput("reset_rd_data", bus.rd_data, 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_sram_enable", 64'(sram_enable), 64'(0));
        checkOutput("reset_sram_write_en", 64'(sram_write_en), 64'(0));
        checkOutput("reset_sram_addr", 64'(sram_addr), 64'(0));
        checkOutput("reset_sram_wdata", sram_wdata, 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] write 4 beats across the address wrap");
        base = wr_access_cnt;
        applyStimulus(1'b1, 10'h3FE, 8'd3, 0, 64'hA);
        waitIdle();
        checkOutput("t1_write_count", 64'(wr_access_cnt - base), 64'(4));

        $display("[TB] read the same burst, latency and throughput");
        rd_mode = 0;
        applyStimulus(1'b0, 10'h3FE, 8'd3, 0, 64'h0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t2_rd_valid_cycle%0d", c), 64'(bus.rd_valid), 64'(c >= 3 && c <= 6));
            checkOutput($sformatf("t2_done_cycle%0d", c), 64'(done), 64'(c == 7));
        end
        waitIdle();

        $display("[TB] 16-beat read with toggling rd_ready");
        rd_mode = 1;
        base = rd_popped;
        applyStimulus(1'b0, AW'($urandom_range(0, DEPTH - 1)), 8'd15, 0, 64'h0);
        waitIdle();
        checkOutput("t3_beat_count", 64'(rd_popped - base), 64'(16));

        $display("[TB] 2-beat write with gapped wr_valid");
        base = wr_access_cnt;
        applyStimulus(1'b1, 10'h100, 8'd1, 1, 64'h0);
        waitIdle();
        checkOutput("t4_write_count", 64'(wr_access_cnt - base), 64'(2));

        $display("[TB] reset in the middle of an 8-beat read");
        rd_mode = 0;
        base    = rd_popped;
        dseen   = done_seen;
        applyStimulus(1'b0, 10'h3FC, 8'd7, 0, 64'h0);
        for (int n = 0; n < 100 && rd_popped < base + 3; n++) @(posedge clk);
        if (rd_popped < base + 3) reportFail("t5_third_pop", "third beat never delivered");
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t5_rd_valid", 64'(bus.rd_valid), 64'(0));
        checkOutput("t5_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        checkOutput("t5_sram_enable", 64'(sram_enable), 64'(0));
        checkOutput("t5_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        rdata_q.delete();
        raddr_q.delete();
        rd_issued = rd_popped;
        done_exp--;
        repeat (4) begin
            @(negedge clk);
            checkOutput("t5_no_done", 64'(done), 64'(0));
            checkOutput("t5_no_access", 64'(sram_enable), 64'(0));
        end
        checkOutput("t5_done_count", 64'(done_seen), 64'(dseen));
        @(posedge clk);
        #1;

        $display("[TB] back-to-back commands held while busy");
        rd_mode = 2;
        applyStimulus(1'b0, AW'($urandom_range(0, DEPTH - 1)), 8'd5, 0, 64'h0);
        applyStimulus(1'b1, AW'($urandom_range(0, DEPTH - 1)), 8'd3, 2, 64'h0);
        applyStimulus(1'b0, AW'($urandom_range(0, DEPTH - 1)), 8'd2, 0, 64'h0);
        waitIdle();

        $display("[TB] maximum-length bursts");
        applyStimulus(1'b1, 10'h380, 8'hFF, 2, 64'h0);
        applyStimulus(1'b0, 10'h380, 8'hFF, 0, 64'h0);
        waitIdle();

        $display("[TB] randomized bursts");
        for (int t = 0; t < 24; t++) begin
            rd_mode = $urandom_range(0, 2);
            applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                          ($urandom_range(0, 7) == 0) ? LW'($urandom_range(16, 63)) : LW'($urandom_range(0, 15)),
                          $urandom_range(0, 2), 64'h0);
            if ($urandom_range(0, 3) == 0) waitIdle();
        end
        waitIdle();

        repeat (3) @(negedge clk);
        checkOutput("done_count", 64'(done_seen), 64'(done_exp));
        checkOutput("scoreboard_empty", 64'(rdata_q.size() + raddr_q.size() + wexp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
